// File: rtl/eq_pkg.sv
// Shared types and helpers for the equivalence-check sequencer.
package eq_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } st_t;

  // Default Fibonacci tap mask for a 14-bit LFSR (taps 14,5,3,1).
  localparam logic [13:0] DEF_LFSR_TAPS = 14'h2015;

  // One Fibonacci step: shift left, feed parity of tapped bits into bit 0.
  // Callers truncate the result to their own width.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input logic [31:0] taps);
    return (cur << 1) | {31'd0, ^(cur & taps)};
  endfunction

endpackage

// File: rtl/eq_vec_gen.sv
// Vector generator: counting or LFSR sequence, loaded at run start and stepped per vector.
module eq_vec_gen
  import eq_pkg::*;
#(
  parameter int unsigned     IN_W = 14,
  parameter logic [IN_W-1:0] TAPS = IN_W'(DEF_LFSR_TAPS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic            i_mode,
  input  logic [IN_W-1:0] i_seed,
  output logic [IN_W-1:0] o_vec
);

  logic [IN_W-1:0] r_vec;
  logic            r_mode;
  logic [IN_W-1:0] w_lfsr;
  logic [IN_W-1:0] w_one;

  assign w_one  = {{(IN_W-1){1'b0}}, 1'b1};
  assign w_lfsr = IN_W'(lfsr_next(32'(r_vec), 32'(TAPS)));
  assign o_vec  = r_vec;

  // Load latches the mode for the whole run; a zero seed would lock the LFSR, so use 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec  <= '0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_mode <= i_mode;
      if (!i_mode)            r_vec <= '0;
      else if (i_seed == '0)  r_vec <= w_one;
      else                    r_vec <= i_seed;
    end else if (i_step) begin
      r_vec <= r_mode ? w_lfsr : r_vec + w_one;
    end
  end

endmodule

// File: rtl/eq_check_sequencer.sv
// Drives a shared vector into DUT and golden netlists, compares their outputs,
// counts mismatches (saturating) and captures the first failing vector.
module eq_check_sequencer
  import eq_pkg::*;
#(
  parameter int unsigned     IN_W      = 14,
  parameter int unsigned     OUT_W     = 8,
  parameter int unsigned     CNT_W     = 16,
  parameter int unsigned     LAT       = 0,
  parameter logic [IN_W-1:0] LFSR_TAPS = IN_W'(DEF_LFSR_TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [IN_W-1:0]  seed,
  input  logic [IN_W:0]    num_vec,
  output logic [IN_W-1:0]  vec_o,
  output logic             vec_valid,
  input  logic [OUT_W-1:0] dut_o,
  input  logic [OUT_W-1:0] gold_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             ff_valid,
  output logic [IN_W-1:0]  ff_vec,
  output logic [OUT_W-1:0] ff_diff
);

  st_t              r_state;
  logic [IN_W:0]    r_remain;
  logic             r_vec_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_mism;
  logic             r_ff_valid;
  logic [IN_W-1:0]  r_ff_vec;
  logic [OUT_W-1:0] r_ff_diff;

  logic             w_idle_like;
  logic             w_active;
  logic             w_flush;
  logic             w_load;
  logic             w_step;
  logic [IN_W-1:0]  w_gen_vec;
  logic             w_cmp_valid;
  logic [IN_W-1:0]  w_cmp_vec;
  logic             w_pipe_busy;
  logic             w_miscompare;

  assign w_idle_like  = (r_state == IDLE) || (r_state == DONE);
  assign w_active     = (r_state == RUN) || (r_state == DRAIN);
  assign w_flush      = abort && w_active;
  assign w_load       = start && w_idle_like && (num_vec != '0);
  assign w_step       = (r_state == RUN) && !abort && (r_remain != {{IN_W{1'b0}}, 1'b1});
  assign w_miscompare = w_cmp_valid && (dut_o != gold_o);

  eq_vec_gen #(
    .IN_W (IN_W),
    .TAPS (LFSR_TAPS)
  ) u_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_mode (mode),
    .i_seed (seed),
    .o_vec  (w_gen_vec)
  );

  // Tag pipeline: {valid, vector} delayed LAT cycles to line up with the netlist outputs.
  if (LAT == 0) begin : g_nolat
    assign w_cmp_valid = r_vec_valid;
    assign w_cmp_vec   = w_gen_vec;
    assign w_pipe_busy = 1'b0;
  end else begin : g_lat
    logic [LAT-1:0]  r_pv;
    logic [IN_W-1:0] r_pvec [LAT];

    // Shift tags each cycle; abort drops every in-flight valid bit.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_pv <= '0;
        for (int i = 0; i < LAT; i++) r_pvec[i] <= '0;
      end else begin
        r_pv[0]   <= r_vec_valid && !w_flush;
        r_pvec[0] <= w_gen_vec;
        for (int i = 1; i < LAT; i++) begin
          r_pv[i]   <= r_pv[i-1] && !w_flush;
          r_pvec[i] <= r_pvec[i-1];
        end
      end
    end

    assign w_cmp_valid = r_pv[LAT-1];
    assign w_cmp_vec   = r_pvec[LAT-1];
    assign w_pipe_busy = |r_pv;
  end

  // Control FSM plus compare/result registers; a start clears results after any compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remain    <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_mism      <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_vec    <= '0;
      r_ff_diff   <= '0;
    end else begin
      // The compare still counts on the abort edge.
      if (w_miscompare) begin
        if (r_mism != '1) r_mism <= r_mism + {{(CNT_W-1){1'b0}}, 1'b1};
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_vec   <= w_cmp_vec;
          r_ff_diff  <= dut_o ^ gold_o;
        end
      end

      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_mism     <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_ff_diff  <= '0;
            if (num_vec != '0) begin
              r_state     <= RUN;
              r_remain    <= num_vec;
              r_vec_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
              r_pass      <= 1'b0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
          end else if (r_remain == {{IN_W{1'b0}}, 1'b1}) begin
            r_state     <= DRAIN;
            r_vec_valid <= 1'b0;
          end else begin
            r_remain <= r_remain - {{IN_W{1'b0}}, 1'b1};
          end
        end
        DRAIN: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!w_pipe_busy) begin
            // Pipeline empty: the last compare happened on an earlier edge.
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_mism == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign vec_o     = w_gen_vec;
  assign vec_valid = r_vec_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign mism_cnt  = r_mism;
  assign ff_valid  = r_ff_valid;
  assign ff_vec    = r_ff_vec;
  assign ff_diff   = r_ff_diff;

endmodule

// File: tb/tb_eq_check_sequencer.sv
// Directed bench: three sequencer instances (LAT=0, LAT=2, CNT_W=4) share stimulus.
module tb_eq_check_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [13:0] seed = '0;
  logic [14:0] num_vec = '0;
  int          tmode = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Netlist stand-ins: a fixed DUT function and a selectable golden variant.
  function automatic logic [7:0] f_dut(input logic [13:0] v);
    return v[7:0] ^ v[13:6];
  endfunction

  function automatic logic [7:0] f_gold(input logic [13:0] v, input int t);
    case (t)
      1:       return f_dut(v) ^ ((v == 14'h0123) ? 8'h04 : 8'h00);
      2:       return ~f_dut(v);
      default: return f_dut(v);
    endcase
  endfunction

  // Instance 0: LAT=0
  logic [13:0] vec0;  logic val0, busy0, done0, pass0, ffv0;
  logic [15:0] mism0; logic [13:0] ffvec0; logic [7:0] ffd0, dut0, gold0;
  assign dut0  = f_dut(vec0);
  assign gold0 = f_gold(vec0, tmode);

  eq_check_sequencer #(.LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .num_vec(num_vec), .vec_o(vec0), .vec_valid(val0), .dut_o(dut0), .gold_o(gold0),
    .busy(busy0), .done(done0), .pass(pass0), .mism_cnt(mism0), .ff_valid(ffv0),
    .ff_vec(ffvec0), .ff_diff(ffd0)
  );

  // Instance 2: LAT=2, netlist outputs delayed two cycles behind vec_o
  logic [13:0] vec2, d1, d2; logic val2, busy2, done2, pass2, ffv2;
  logic [15:0] mism2; logic [13:0] ffvec2; logic [7:0] ffd2, dut2, gold2;
  always @(posedge clk) begin
    d1 <= vec2;
    d2 <= d1;
  end
  assign dut2  = f_dut(d2);
  assign gold2 = f_gold(d2, tmode);

  eq_check_sequencer #(.LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .num_vec(num_vec), .vec_o(vec2), .vec_valid(val2), .dut_o(dut2), .gold_o(gold2),
    .busy(busy2), .done(done2), .pass(pass2), .mism_cnt(mism2), .ff_valid(ffv2),
    .ff_vec(ffvec2), .ff_diff(ffd2)
  );

  // Instance 4: CNT_W=4
  logic [13:0] vec4; logic val4, busy4, done4, pass4, ffv4;
  logic [3:0]  mism4; logic [13:0] ffvec4; logic [7:0] ffd4, dut4, gold4;
  assign dut4  = f_dut(vec4);
  assign gold4 = f_gold(vec4, tmode);

  eq_check_sequencer #(.LAT(0), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .num_vec(num_vec), .vec_o(vec4), .vec_valid(val4), .dut_o(dut4), .gold_o(gold4),
    .busy(busy4), .done(done4), .pass(pass4), .mism_cnt(mism4), .ff_valid(ffv4),
    .ff_vec(ffvec4), .ff_diff(ffd4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent 14-bit LFSR model, taps at bits 13,4,2,0.
  function automatic logic [13:0] model_lfsr(input logic [13:0] v);
    return {v[12:0], v[13] ^ v[4] ^ v[2] ^ v[0]};
  endfunction

  logic [13:0] seen [3];

  // Pulse start, follow u0's vectors against the model, return the edge count to done.
  task automatic run(input logic m, input logic [13:0] s, input int n, input int sel,
                     output int cyc, output int nvalid, output int seq_err);
    logic [13:0] exp_v;
    logic        d;
    int          k;
    exp_v   = m ? ((s == '0) ? 14'd1 : s) : 14'd0;
    nvalid  = 0;
    seq_err = 0;
    mode    = m;
    seed    = s;
    num_vec = 15'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (k < n + 20) begin
      d = (sel == 2) ? done2 : done0;
      if (d) break;
      if (val0) begin
        if (nvalid < 3) seen[nvalid] = vec0;
        if (vec0 !== exp_v) seq_err++;
        exp_v = m ? model_lfsr(exp_v) : exp_v + 14'd1;
        nvalid++;
      end
      @(posedge clk); #1;
      k++;
    end
    cyc = k;
    repeat (4) @(posedge clk);
    #1;
  endtask

  int cyc, nv, se;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_vec", 32'(vec0), 32'h0);
    check("rst_valid", 32'(val0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_done", 32'(done0), 32'h0);
    check("rst_pass", 32'(pass0), 32'h0);
    check("rst_mism", 32'(mism0), 32'h0);
    check("rst_ffv", 32'(ffv0), 32'h0);

    // Exhaustive counting run, matching models
    tmode = 0;
    run(1'b0, 14'h0, 16384, 0, cyc, nv, se);
    check("exh_done_cyc", 32'(cyc), 32'd16385);
    check("exh_nvalid", 32'(nv), 32'd16384);
    check("exh_seq_err", 32'(se), 32'd0);
    check("exh_done", 32'(done0), 32'h1);
    check("exh_pass", 32'(pass0), 32'h1);
    check("exh_mism", 32'(mism0), 32'h0);
    check("exh_ffv", 32'(ffv0), 32'h0);
    check("exh_busy", 32'(busy0), 32'h0);

    // LFSR with zero seed
    run(1'b1, 14'h0, 3, 0, cyc, nv, se);
    check("lfsr_v0", 32'(seen[0]), 32'h0001);
    check("lfsr_v1", 32'(seen[1]), 32'h0003);
    check("lfsr_v2", 32'(seen[2]), 32'h0007);
    check("lfsr_nvalid", 32'(nv), 32'd3);
    check("lfsr_done_cyc", 32'(cyc), 32'd4);
    check("lfsr_pass", 32'(pass0), 32'h1);

    // Single fault at 0x0123, LAT=2
    tmode = 1;
    run(1'b0, 14'h0, 1024, 2, cyc, nv, se);
    check("flt_done_cyc", 32'(cyc), 32'd1027);
    check("flt_mism", 32'(mism2), 32'd1);
    check("flt_ffv", 32'(ffv2), 32'h1);
    check("flt_ffvec", 32'(ffvec2), 32'h0123);
    check("flt_ffdiff", 32'(ffd2), 32'h04);
    check("flt_pass", 32'(pass2), 32'h0);
    check("flt_done", 32'(done2), 32'h1);
    check("flt_mism_lat0", 32'(mism0), 32'd1);

    // num_vec = 0: done and pass right after the start edge, results cleared
    tmode   = 0;
    num_vec = '0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", 32'(done0), 32'h1);
    check("zero_pass", 32'(pass0), 32'h1);
    check("zero_valid", 32'(val0), 32'h0);
    check("zero_mism", 32'(mism0), 32'h0);
    @(posedge clk); #1;
    check("zero_valid2", 32'(val0), 32'h0);

    // Saturation with every vector mismatching
    tmode = 2;
    run(1'b0, 14'h0, 20, 0, cyc, nv, se);
    check("sat_mism4", 32'(mism4), 32'd15);
    check("sat_mism16", 32'(mism0), 32'd20);
    check("sat_ffvec", 32'(ffvec4), 32'h0);
    check("sat_ffdiff", 32'(ffd4), 32'hFF);
    check("sat_pass", 32'(pass4), 32'h0);

    // Abort (with simultaneous start) on edge 50 of a 1000-vector run
    tmode   = 2;
    mode    = 1'b0;
    num_vec = 15'd1000;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    check("abt_done", 32'(done0), 32'h0);
    check("abt_busy", 32'(busy0), 32'h0);
    check("abt_valid", 32'(val0), 32'h0);
    check("abt_mism", 32'(mism0), 32'd50);
    check("abt_mism_lat2", 32'(mism2), 32'd48);
    check("abt_ffvec", 32'(ffvec0), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("abt_still_idle", 32'(busy2), 32'h0);
    check("abt_done_lat2", 32'(done2), 32'h0);

    // Restart clears results and begins again at vector 0
    num_vec = 15'd1000;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rs_mism", 32'(mism0), 32'h0);
    check("rs_ffv", 32'(ffv0), 32'h0);
    check("rs_vec", 32'(vec0), 32'h0);
    check("rs_valid", 32'(val0), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("rs_mism3", 32'(mism0), 32'd3);
    check("rs_vec3", 32'(vec0), 32'h3);

    // Asynchronous reset mid-run
    rst = 1'b1;
    #1;
    check("mrst_vec", 32'(vec0), 32'h0);
    check("mrst_valid", 32'(val0), 32'h0);
    check("mrst_busy", 32'(busy0), 32'h0);
    check("mrst_done", 32'(done0), 32'h0);
    check("mrst_mism", 32'(mism0), 32'h0);
    check("mrst_ffv", 32'(ffv0), 32'h0);
    check("mrst_ffvec", 32'(ffvec0), 32'h0);
    check("mrst_ffdiff", 32'(ffd0), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/eq_check_sequencer.md
Name: eq_check_sequencer

Overview:
- Sequences stimulus into the optimized combinational netlist (DUT) and its golden counterpart, which share one input vector.
- Compares the two 8-bit output words vector by vector, counts mismatches and records the first failing vector.
- Sits beside the optimized-design cone in the on-chip equivalence and regression harness used to validate each optimized candidate.

Parameters:
- IN_W, 14, width of the shared primary-input vector.
- OUT_W, 8, width of each compared output word.
- CNT_W, 16, mismatch counter width; the counter saturates.
- LAT, 0, extra register stages (0..7) between vec_o and the dut_o/gold_o sample point.
- LFSR_TAPS, 14'h2015, Fibonacci tap mask (taps 14,5,3,1).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run.
- abort  in  1  terminates the current run.
- mode  in  1  0 = counting vectors 0,1,2..; 1 = LFSR vectors.
- seed  in  IN_W  LFSR start value; 0 is replaced by 1.
- num_vec  in  IN_W+1  number of vectors to apply (up to 2^IN_W).
- vec_o  out  IN_W  registered vector driven to both netlists.
- vec_valid  out  1  vec_o carries a live vector this cycle.
- dut_o  in  OUT_W  DUT outputs.
- gold_o  in  OUT_W  golden outputs.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  level; state is DONE.
- pass  out  1  done and mism_cnt==0.
- mism_cnt  out  CNT_W  saturating mismatch count.
- ff_valid  out  1  a first failure has been captured.
- ff_vec  out  IN_W  vector of the first failure.
- ff_diff  out  OUT_W  dut_o XOR gold_o at the first failure.

Behaviour:
- Reset: state IDLE; all outputs 0; vector generator 0; tag pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, start=1, num_vec!=0: clear mism_cnt and ff_*; load the generator (0 in counting mode, seed or 1 in LFSR mode); go to RUN.
- IDLE or DONE, start=1, num_vec==0: go to DONE next cycle with pass=1.
- start is ignored in RUN and DRAIN.
- RUN issues one vector per cycle, starting the cycle after the start edge.
  - Counting mode: value increments by 1.
  - LFSR mode: next = {cur[IN_W-2:0], ^(cur & LFSR_TAPS)}.
  - After the num_vec-th vector has issued, go to DRAIN; vec_valid drops.
- Compare pipeline: a shift register of depth LAT carries {valid, vector}.
  - Compare happens at the clock edge where the tagged vector reaches stage LAT. With LAT=0, dut_o and gold_o are sampled in the same cycle that vec_o is valid.
- Compare action: if valid and dut_o != gold_o:
  - mism_cnt increments, saturating at all-ones.
  - If ff_valid==0, latch ff_vec and ff_diff and set ff_valid.
- DRAIN waits until the pipeline is empty (LAT cycles), then goes to DONE.
- Timing: done rises N+LAT+1 cycles after the start edge.
- DONE holds all results until the next start.
- abort=1 in RUN or DRAIN:
  - Next state IDLE; pipeline valid bits cleared; done stays 0.
  - mism_cnt and ff_* retain partial values; the compare at the abort edge still counts.
- abort has no effect in IDLE or DONE.
- abort and start together: abort wins.
- num_vec = 2^IN_W in counting mode covers the full space; the counter wraps to 0 only after the last vector and is not reused.
- LFSR mode does not check num_vec > 2^IN_W-1; repeated vectors are permitted.
- rst mid-run: immediate return to the reset state; no done.

Decomposition:
- Shared package eq_pkg:
  - state enum st_t {IDLE, RUN, DRAIN, DONE}.
  - Default LFSR_TAPS constant for 14 bits.
  - Function lfsr_next(cur, taps).
- One sub-module, eq_vec_gen: counting/LFSR generator with load, step and mode. The FSM, tag pipeline and compare stay in the top module.

Test Plan:
- Exhaustive, mode=0, num_vec=16384, gold_o=dut_o, LAT=0 -> 16384 vec_valid cycles with vec_o 0..0x3FFF; done at start+16385; pass=1; mism_cnt=0; ff_valid=0.
- Single fault, mode=0, num_vec=1024, gold_o = dut_o^8'h04 only when vector==14'h0123, LAT=2 -> mism_cnt=1, ff_vec=0x0123, ff_diff=0x04, pass=0; done at start+1027.
- LFSR, seed=0, num_vec=3 -> vec_o sequence 0x0001, 0x0003, 0x0007; done asserted; pass=1 with matching models.
- num_vec=0 with start -> done=1 and pass=1 the cycle after start; vec_valid never asserts.
- CNT_W=4, every vector mismatching, num_vec=20 -> mism_cnt=15 (saturated); ff_vec=0 in counting mode.
- abort at cycle 50 of a 1000-vector run, then a new start -> IDLE, done=0 after abort; the new start clears mism_cnt and ff_valid and the run restarts at vector 0. rst asserted mid-run -> all outputs 0 immediately.
